// File: rtl/ibex_pkg.sv
// Shared constants and types for the register-file write arbiter.
package ibex_pkg;

   localparam int LoadQDepthDefault = 2;

   typedef struct packed {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } rf_wr_t;

endpackage

// File: rtl/ibex_rf_wr_arbiter_if.sv
// Pipeline-side bundle of the write arbiter: ID/EX writes, load tracking, hazards and RF port.
interface ibex_rf_wr_arbiter_if
   import ibex_pkg::*;
#(
   parameter int LoadQDepth = LoadQDepthDefault
);

   logic                            id_wr_valid_i;
   logic                            id_wr_ready_o;
   logic [4:0]                      id_waddr_i;
   logic [31:0]                     id_wdata_i;
   logic                            load_issue_i;
   logic [4:0]                      load_rd_i;
   logic                            load_issue_ready_o;
   logic                            lsu_resp_valid_i;
   logic                            lsu_resp_err_i;
   logic [31:0]                     lsu_rdata_i;
   logic [4:0]                      rs1_addr_i;
   logic [4:0]                      rs2_addr_i;
   logic                            rd_hazard_o;
   logic                            waw_hazard_o;
   logic                            rf_we_o;
   logic [4:0]                      rf_waddr_o;
   logic [31:0]                     rf_wdata_o;
   logic [$clog2(LoadQDepth+1)-1:0] outstanding_o;
   logic                            orphan_resp_o;

   modport master (
      output id_wr_valid_i, id_waddr_i, id_wdata_i,
      output load_issue_i, load_rd_i,
      output lsu_resp_valid_i, lsu_resp_err_i, lsu_rdata_i,
      output rs1_addr_i, rs2_addr_i,
      input  id_wr_ready_o, load_issue_ready_o, rd_hazard_o, waw_hazard_o,
      input  rf_we_o, rf_waddr_o, rf_wdata_o, outstanding_o, orphan_resp_o
   );

   modport slave (
      input  id_wr_valid_i, id_waddr_i, id_wdata_i,
      input  load_issue_i, load_rd_i,
      input  lsu_resp_valid_i, lsu_resp_err_i, lsu_rdata_i,
      input  rs1_addr_i, rs2_addr_i,
      output id_wr_ready_o, load_issue_ready_o, rd_hazard_o, waw_hazard_o,
      output rf_we_o, rf_waddr_o, rf_wdata_o, outstanding_o, orphan_resp_o
   );

endinterface

// File: rtl/ibex_rf_wr_addr_fifo.sv
// Destination-register FIFO for outstanding loads; exposes every slot for hazard compares.
module ibex_rf_wr_addr_fifo #(
   parameter int Depth = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic [4:0]                 push_addr_i,
   input  logic                       pop_i,
   output logic [4:0]                 head_addr_o,
   output logic [$clog2(Depth+1)-1:0] count_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [Depth-1:0]           entry_valid_o,
   output logic [Depth-1:0][4:0]      entry_addr_o
);

   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CntW = $clog2(Depth + 1);

   logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CntW-1:0] count_q, count_d;
   logic [4:0]      mem_q [Depth];
   logic            push_ok, pop_ok;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      head_d  = pop_ok  ? ptr_inc(head_q) : head_q;
      tail_d  = push_ok ? ptr_inc(tail_q) : tail_q;
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Slot contents are qualified by count alone, so the storage itself is never reset.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[tail_q] <= push_addr_i;
   end

   assign head_addr_o = mem_q[head_q];
   assign count_o     = count_q;

   for (genvar gi = 0; gi < Depth; gi++) begin : g_entry
      logic [31:0] raw_off, offset;
      // Distance of this slot from the head, modulo Depth.
      assign raw_off = 32'(gi) + 32'(Depth) - 32'(head_q);
      assign offset  = (raw_off >= 32'(Depth)) ? raw_off - 32'(Depth) : raw_off;
      assign entry_valid_o[gi] = (offset < 32'(count_q));
      assign entry_addr_o[gi]  = mem_q[gi];
   end

endmodule

// File: rtl/ibex_rf_wr_arbiter.sv
// Arbitrates LSU load responses and ID/EX results onto one registered RF write port.
module ibex_rf_wr_arbiter
   import ibex_pkg::*;
#(
   parameter int LoadQDepth = LoadQDepthDefault
) (
   input  logic                clk_i,
   input  logic                rst_i,
   ibex_rf_wr_arbiter_if.slave bus
);

   localparam int CntW = $clog2(LoadQDepth + 1);

   logic                       fifo_full, fifo_empty, pop;
   logic [4:0]                 head_rd;
   logic [CntW-1:0]            count;
   logic [LoadQDepth-1:0]      entry_valid;
   logic [LoadQDepth-1:0][4:0] entry_addr;
   logic [LoadQDepth-1:0]      rs1_hit, rs2_hit, waw_hit;
   rf_wr_t                     wr_q, wr_d;
   logic                       orphan_q, orphan_d;

   assign pop = bus.lsu_resp_valid_i & ~fifo_empty;

   ibex_rf_wr_addr_fifo #(
      .Depth(LoadQDepth)
   ) u_addr_fifo (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .push_i       (bus.load_issue_i),
      .push_addr_i  (bus.load_rd_i),
      .pop_i        (pop),
      .head_addr_o  (head_rd),
      .count_o      (count),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty),
      .entry_valid_o(entry_valid),
      .entry_addr_o (entry_addr)
   );

   assign bus.load_issue_ready_o = ~fifo_full;
   assign bus.id_wr_ready_o      = ~bus.lsu_resp_valid_i;
   assign bus.outstanding_o      = count;

   // Load responses win; address/data hold their last value when nothing is written.
   always_comb begin
      wr_d    = wr_q;
      wr_d.we = 1'b0;
      if (pop) begin
         if (!bus.lsu_resp_err_i && head_rd != 5'd0) begin
            wr_d.we    = 1'b1;
            wr_d.waddr = head_rd;
            wr_d.wdata = bus.lsu_rdata_i;
         end
      end else if (bus.id_wr_valid_i && bus.id_wr_ready_o && bus.id_waddr_i != 5'd0) begin
         wr_d.we    = 1'b1;
         wr_d.waddr = bus.id_waddr_i;
         wr_d.wdata = bus.id_wdata_i;
      end
   end

   assign orphan_d = orphan_q
                   | (bus.load_issue_i & fifo_full)
                   | (bus.lsu_resp_valid_i & fifo_empty);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q     <= '0;
         orphan_q <= 1'b0;
      end else begin
         wr_q     <= wr_d;
         orphan_q <= orphan_d;
      end
   end

   assign bus.rf_we_o       = wr_q.we;
   assign bus.rf_waddr_o    = wr_q.waddr;
   assign bus.rf_wdata_o    = wr_q.wdata;
   assign bus.orphan_resp_o = orphan_q;

   for (genvar gi = 0; gi < LoadQDepth; gi++) begin : g_cmp
      assign rs1_hit[gi] = entry_valid[gi] & (entry_addr[gi] == bus.rs1_addr_i);
      assign rs2_hit[gi] = entry_valid[gi] & (entry_addr[gi] == bus.rs2_addr_i);
      assign waw_hit[gi] = entry_valid[gi] & (entry_addr[gi] == bus.id_waddr_i);
   end

   // x0 never creates a dependency, even though x0 loads still occupy a slot.
   assign bus.rd_hazard_o =
        ((bus.rs1_addr_i != 5'd0) & ((|rs1_hit) | (wr_q.we & (wr_q.waddr == bus.rs1_addr_i))))
      | ((bus.rs2_addr_i != 5'd0) & ((|rs2_hit) | (wr_q.we & (wr_q.waddr == bus.rs2_addr_i))));
   assign bus.waw_hazard_o = (bus.id_waddr_i != 5'd0) & (|waw_hit);

endmodule

// File: doc/ibex_rf_wr_arbiter.md
IBEX_RF_WR_ARBITER -- requirements
Module: ibex_rf_wr_arbiter

Interface
REQ-001 SHALL have parameter LoadQDepth, default 2, meaning the maximum number of outstanding loads tracked (legal range 1..4).
REQ-002 SHALL have ports: clk_i input 1, the clock; rst_i input 1, the reset; synchronous, active-high.
REQ-003 SHALL have id_wr_valid_i input 1, an ID/EX result write request; id_wr_ready_o output 1, write accepted; id_waddr_i input 5; id_wdata_i input 32.
REQ-004 SHALL have load_issue_i input 1, a load issued to the LSU; load_rd_i input 5, its destination; load_issue_ready_o output 1, the queue has space.
REQ-005 SHALL have lsu_resp_valid_i input 1; lsu_resp_err_i input 1; lsu_rdata_i input 32, the load response.
REQ-006 SHALL have rs1_addr_i and rs2_addr_i inputs 5 each; rd_hazard_o output 1, a RAW hazard on rs1/rs2; waw_hazard_o output 1, id_waddr_i matches a pending load.
REQ-007 SHALL have rf_we_o output 1, rf_waddr_o output 5 and rf_wdata_o output 32, forming the register-file write port.
REQ-008 SHALL have outstanding_o output $clog2(LoadQDepth+1), the pending load count; orphan_resp_o output 1, a sticky protocol error.

Function
REQ-009 SHALL hold a FIFO of load destination addresses, with depth LoadQDepth, a head pointer, a tail pointer and a count; pointers wrap modulo LoadQDepth.
REQ-010 SHALL assert load_issue_ready_o = (count < LoadQDepth); the value is independent of same-cycle pops.
REQ-011 SHALL enqueue load_rd_i when load_issue_i & load_issue_ready_o; load_issue_i while full SHALL be dropped and SHALL set orphan_resp_o.
REQ-012 SHALL pop the head entry on lsu_resp_valid_i when count>0, whether or not err is set.
REQ-013 SHALL treat lsu_resp_valid_i with count==0 (before this cycle's enqueue) as an orphan: no pop, no write, orphan_resp_o set.
REQ-014 SHALL allow enqueue and pop in the same cycle; count is then unchanged and both pointers advance.
REQ-015 On pop with ~lsu_resp_err_i and head rd!=0, SHALL register a write of lsu_rdata_i to head rd.
REQ-016 On pop with lsu_resp_err_i, SHALL perform no write.
REQ-017 SHALL give LSU responses priority: id_wr_ready_o = ~lsu_resp_valid_i.
REQ-018 On id_wr_valid_i & id_wr_ready_o, SHALL register a write of id_wdata_i to id_waddr_i; a write to x0 is accepted and suppressed.
REQ-019 SHALL present rf_we_o/rf_waddr_o/rf_wdata_o as registers, one cycle after acceptance; rf_we_o is high for exactly one cycle per write.
REQ-020 SHALL keep rf_waddr_o/rf_wdata_o stable when rf_we_o=0.
REQ-021 SHALL compute rd_hazard_o combinationally: rs1 or rs2 (nonzero) matches any valid queue entry, or matches rf_waddr_o while rf_we_o=1.
REQ-022 SHALL compute waw_hazard_o combinationally: id_waddr_i (nonzero) matches any valid queue entry.
REQ-023 SHALL never raise a hazard for address 0; entries for x0 loads are still queued to preserve response order.
REQ-024 SHALL drive outstanding_o from the registered count.
REQ-025 orphan_resp_o SHALL remain set until reset.

Reset
REQ-026 SHALL, while rst_i is high at a clock edge, clear count, pointers, rf_we_o, rf_waddr_o, rf_wdata_o and orphan_resp_o to 0.
REQ-027 SHALL discard all pending queue entries on reset mid-operation; a later response counts as an orphan.
REQ-028 SHALL have queue entry storage need no reset, because valid entries are defined by count only.

Structure
REQ-029 SHALL place the default LoadQDepth constant and the rf write struct typedef (we, waddr, wdata) in ibex_pkg.
REQ-030 SHALL implement the address FIFO as the sub-module ibex_rf_wr_addr_fifo, which exposes entry-valid vector and entry addresses for the hazard compare.

Verification
REQ-031 SHALL cover: issue load rd=5, then response data 0xDEADBEEF -> next cycle rf_we_o=1, waddr=5, wdata=0xDEADBEEF, outstanding_o 1->0.
REQ-032 SHALL cover: ID write x7=0x11 in the same cycle as a load response rd=3 -> id_wr_ready_o=0; x3 is written; ID writes x7 the following cycle.
REQ-033 SHALL cover: issue loads rd=4 and rd=9 with Depth=2 -> load_issue_ready_o=0; third issue sets orphan_resp_o; rs2=9 -> rd_hazard_o=1.
REQ-034 SHALL cover: error response for rd=6 -> no rf_we_o, count decrements, rd_hazard_o for rs1=6 clears.
REQ-035 SHALL cover: response with empty queue -> orphan_resp_o=1 and no write; a load to rd=0 plus a response -> no write and no hazard.
REQ-036 SHALL cover: rst_i asserted with 2 pending -> outstanding_o=0, and a subsequent response sets orphan_resp_o.
